// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Mode controller for the minutes/seconds stopwatch. Conditions
//             the raw buttons/switches (2-flop sync, debounce, edge detect),
//             runs the PAUSE/RUN/ADJ state machine, issues one-clk
//             count/clear/increment strobes and drives the digit-blank levels.
//  Ports    : clk        - master clock (all logic is single-clock)
//             reset      - asynchronous, active-low reset
//             tick_1hz   - one-clk enable, advances the counter in RUN
//             tick_2hz   - one-clk enable, increments/blinks in ADJ
//             btn_pause  - raw pause/resume button (active-high)
//             btn_rst    - raw clear button (active-high)
//             sw_adj     - raw adjust-mode switch (1 = adjust)
//             sw_sel     - raw field select (1 = minutes, 0 = seconds)
//             count_en   - strobe: counter advances one second
//             count_clr  - strobe: counter clears to 00:00
//             inc_min    - strobe: minutes +1
//             inc_sec    - strobe: seconds +1
//             blank_min  - level: blank the minutes digits
//             blank_sec  - level: blank the seconds digits
//             mode       - 00 PAUSE, 01 RUN, 10 ADJ
//  Config   : STOPWATCH_BLINK_EN - when defined, the field under adjust
//             blinks; otherwise blank_min/blank_sec are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_rst,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       count_en,
  output logic       count_clr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_ADJ   = 2'b10
  } state_t;

  localparam int N_IN    = 4;
  localparam int I_PAUSE = 0;
  localparam int I_RST   = 1;
  localparam int I_ADJ   = 2;
  localparam int I_SEL   = 3;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1_q, sync2_q;
  logic [N_IN-1:0]  deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q [N_IN];
  logic [DEB_W-1:0] cnt_d [N_IN];
  logic [1:0]       vld_q;
  logic [1:0]       arm_q, arm_d;
  logic [1:0]       press_q, press_d;

  assign raw = {sw_sel, sw_adj, btn_rst, btn_pause};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
    // A button only becomes eligible to generate a press after it has been
    // seen released once the synchroniser holds real samples. This keeps a
    // button held through reset release from producing a spurious press.
    arm_d   = arm_q | ({2{vld_q[1]}} & ~sync2_q[1:0]);
    press_d = deb_d[1:0] & ~deb_q[1:0] & arm_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      vld_q   <= '0;
      arm_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      vld_q   <= {vld_q[0], 1'b1};
      arm_q   <= arm_d;
      press_q <= press_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic press_pause, press_rst, adj, sel;
  assign press_pause = press_q[I_PAUSE];
  assign press_rst   = press_q[I_RST];
  assign adj         = deb_q[I_ADJ];
  assign sel         = deb_q[I_SEL];

  // --------------------------------------------------------------------------
  // State machine and strobes (strobes always use the current, i.e. old, state)
  // --------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   count_en_q, count_en_d;
  logic   count_clr_q, count_clr_d;
  logic   inc_min_q, inc_min_d;
  logic   inc_sec_q, inc_sec_d;

  always_comb begin
    state_d = state_q;
    if (adj) begin
      state_d = ST_ADJ;
    end else if (state_q == ST_ADJ) begin
      state_d = ST_PAUSE;
    end else if (press_pause) begin
      state_d = (state_q == ST_PAUSE) ? ST_RUN : ST_PAUSE;
    end

    // Clear has priority: it masks every other strobe in the same cycle.
    count_clr_d = press_rst;
    count_en_d  = tick_1hz & (state_q == ST_RUN) & ~press_rst;
    inc_min_d   = tick_2hz & (state_q == ST_ADJ) & sel & ~press_rst;
    inc_sec_d   = tick_2hz & (state_q == ST_ADJ) & ~sel & ~press_rst;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PAUSE;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_en_q  <= count_en_d;
      count_clr_q <= count_clr_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
    end
  end

  assign count_en  = count_en_q;
  assign count_clr = count_clr_q;
  assign inc_min   = inc_min_q;
  assign inc_sec   = inc_sec_q;
  assign mode      = state_q;

  // --------------------------------------------------------------------------
  // Blink of the field under adjust
  // --------------------------------------------------------------------------
`ifdef STOPWATCH_BLINK_EN
  logic phase_q, phase_d;

  // Held at 0 outside ADJ so every ADJ entry starts with the field visible.
  always_comb begin
    phase_d = (state_q == ST_ADJ) ? (phase_q ^ tick_2hz) : 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign blank_min = (state_q == ST_ADJ) & sel & phase_q;
  assign blank_sec = (state_q == ST_ADJ) & ~sel & phase_q;
`else
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif

endmodule
`default_nettype wire
